ika9958_cengen: RTL and testbench

- Parametrised successor to the fixed phiH/phiL/CPUCLK divider chain: NCH independent programmable clock-enable channels, all driven by one master clock.
- Each channel produces a registered reference level plus PCEN/NCEN strobes, with per-channel hold (clock pause), masked external phase sync and a post-reset startup delay.
- Sits between the master clock and the timing/CPU consumers.
- Lets one block serve DHCLK/DLCLK/CPUCLK-style outputs and new ratios without hand-built shift registers.

---
 rtl/ika9958_cengen.sv | 140 ++++++++++++++
 tb/tb_ika9958_cengen.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ika9958_cengen.sv
// Programmable clock-enable generator: NCH divider channels off one master clock, with hold,
// masked external phase sync and a post-reset startup delay. Define IKA9958_CENGEN_LOCKDET_EN
// to add the channel-0 sync lock detector (o_LOCKED).
module ika9958_cengen #(
  parameter int NCH     = 3,
  parameter int CW      = 4,
  parameter int RST_DLY = 8
) (
  input  logic              i_XTAL1,
  input  logic              i_RST_n,
  input  logic              i_XTAL_NCEN,
  input  logic [NCH*CW-1:0] i_DIV,
  input  logic [NCH-1:0]    i_HOLD,
  input  logic              i_SYNC_n,
  input  logic [NCH-1:0]    i_SYNC_MASK,
  output logic [NCH-1:0]    o_CLK,
  output logic [NCH-1:0]    o_PCEN,
  output logic [NCH-1:0]    o_NCEN,
`ifdef IKA9958_CENGEN_LOCKDET_EN
  output logic              o_LOCKED,
`endif
  output logic              o_READY
);

  localparam int            SW   = $clog2(RST_DLY + 1);
  localparam logic [SW-1:0] SDLY = SW'(RST_DLY);
  localparam logic [CW:0]   TWO  = {{(CW-1){1'b0}}, 2'b10};

  function automatic logic [CW-1:0] sanitize(input logic [CW-1:0] d);
    return (d == '0) ? CW'(1) : d;
  endfunction

  // Number of counts the level stays high: ceil((d+1)/2).
  function automatic logic [CW:0] high_len(input logic [CW-1:0] d);
    return ({1'b0, d} + TWO) >> 1;
  endfunction

  logic [SW-1:0] st_cnt;
  logic          ready;

  always_ff @(posedge i_XTAL1) begin
    if (!i_RST_n) begin
      st_cnt <= '0;
      ready  <= 1'b0;
    end else if (i_XTAL_NCEN && !ready) begin
      st_cnt <= st_cnt + SW'(1);
      if (st_cnt + SW'(1) == SDLY) ready <= 1'b1;
    end
  end

  // Two-flop synchroniser plus an edge register; the event is the falling edge of i_SYNC_n.
  logic s1, s2, s3, sync_ev;

  always_ff @(posedge i_XTAL1) begin
    if (!i_RST_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else if (i_XTAL_NCEN) begin
      s1 <= i_SYNC_n;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync_ev = s3 & ~s2;

  logic [CW-1:0]  cnt     [NCH];
  logic [CW-1:0]  div_act [NCH];
  logic [CW-1:0]  cnt_nx  [NCH];
  logic [CW-1:0]  div_nx  [NCH];
  logic [NCH-1:0] clk;
  logic [NCH-1:0] clk_nx;
  logic [NCH-1:0] held;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      held[c]   = i_HOLD[c] | ~ready;
      cnt_nx[c] = cnt[c];
      div_nx[c] = div_act[c];
      clk_nx[c] = clk[c];
      if (!held[c]) begin
        if (sync_ev && i_SYNC_MASK[c]) begin
          cnt_nx[c] = '0;
          div_nx[c] = sanitize(i_DIV[c*CW +: CW]);
          clk_nx[c] = 1'b1;
        end else begin
          // New ratio is only picked up at wrap so a period is never cut short.
          if (cnt[c] == div_act[c]) begin
            cnt_nx[c] = '0;
            div_nx[c] = sanitize(i_DIV[c*CW +: CW]);
          end else begin
            cnt_nx[c] = cnt[c] + CW'(1);
          end
          clk_nx[c] = ({1'b0, cnt_nx[c]} < high_len(div_nx[c]));
        end
      end
    end
  end

  always_ff @(posedge i_XTAL1) begin
    if (!i_RST_n) begin
      for (int c = 0; c < NCH; c++) begin
        cnt[c]     <= '0;
        div_act[c] <= CW'(1);
      end
      clk <= '0;
    end else if (i_XTAL_NCEN) begin
      for (int c = 0; c < NCH; c++) begin
        cnt[c]     <= cnt_nx[c];
        div_act[c] <= div_nx[c];
      end
      clk <= clk_nx;
    end
  end

  assign o_CLK   = clk;
  assign o_PCEN  = {NCH{i_XTAL_NCEN & i_RST_n}} & ~clk &  clk_nx;
  assign o_NCEN  = {NCH{i_XTAL_NCEN & i_RST_n}} &  clk & ~clk_nx;
  assign o_READY = ready;

`ifdef IKA9958_CENGEN_LOCKDET_EN
  // Counts consecutive sync events that land exactly on a natural channel-0 wrap.
  logic [1:0] lock_cnt;

  always_ff @(posedge i_XTAL1) begin
    if (!i_RST_n) begin
      lock_cnt <= 2'd0;
    end else if (i_XTAL_NCEN && sync_ev) begin
      if (!held[0] && (cnt[0] == div_act[0]))
        lock_cnt <= (lock_cnt == 2'd3) ? 2'd3 : lock_cnt + 2'd1;
      else
        lock_cnt <= 2'd0;
    end
  end

  assign o_LOCKED = (lock_cnt == 2'd3);
`endif

endmodule

// File: tb/tb_ika9958_cengen.sv
// Bench for ika9958_cengen: expected per-channel periods are queued before stimulus and
// popped as each rising o_CLK edge is observed.
module tb_ika9958_cengen;

  localparam int NCH     = 3;
  localparam int CW      = 4;
  localparam int RST_DLY = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ncen;
  logic [NCH*CW-1:0] div;
  logic [NCH-1:0]    hold;
  logic              sync_n;
  logic [NCH-1:0]    mask;
  logic [NCH-1:0]    o_CLK;
  logic [NCH-1:0]    o_PCEN;
  logic [NCH-1:0]    o_NCEN;
  logic              o_READY;
`ifdef IKA9958_CENGEN_LOCKDET_EN
  logic              o_LOCKED;
`endif

  ika9958_cengen #(.NCH(NCH), .CW(CW), .RST_DLY(RST_DLY)) dut (
    .i_XTAL1     (clk),
    .i_RST_n     (rst_n),
    .i_XTAL_NCEN (ncen),
    .i_DIV       (div),
    .i_HOLD      (hold),
    .i_SYNC_n    (sync_n),
    .i_SYNC_MASK (mask),
    .o_CLK       (o_CLK),
    .o_PCEN      (o_PCEN),
    .o_NCEN      (o_NCEN),
`ifdef IKA9958_CENGEN_LOCKDET_EN
    .o_LOCKED    (o_LOCKED),
`endif
    .o_READY     (o_READY)
  );

  always #5 clk = ~clk;

  typedef struct { int per; int hi; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int checks   = 0;
  int failures = 0;

  task automatic push_exp(input int c, input int per, input int hi, input int num);
    exp_t e;
    e.per = per;
    e.hi  = hi;
    for (int k = 0; k < num; k++) begin
      case (c)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic wait_rise(input int c, input string tag);
    logic p;
    bit   seen;
    seen = 1'b0;
    p    = o_CLK[c];
    for (int k = 0; k < 64; k++) begin
      @(negedge clk); #1;
      if (o_CLK[c] && !p) begin
        seen = 1'b1;
        break;
      end
      p = o_CLK[c];
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s rise_timeout ch%0d got no rise expected rise within 64 cycles", tag, c);
    end
  endtask

  // Walks nsamp cycles, scoring every rise-to-rise window against the queued expectations.
  task automatic measure(input string tag, input int nsamp, input logic [2:0] armed,
                         input logic [2:0] hmask, input int hlen, input int sync_at,
                         input bit toggle);
    int         last[3];
    int         hi[3];
    int         pc[3];
    int         nc[3];
    logic [2:0] prev, cur;
    bit         both, gated, have;
    exp_t       e;
    both  = 1'b0;
    gated = 1'b0;
    hold  = hmask;
    if (sync_at == 0) sync_n = 1'b0;
    if (toggle) ncen = 1'b0;
    #1;
    prev = o_CLK;
    for (int c = 0; c < 3; c++) begin
      last[c] = armed[c] ? 0 : -1;
      hi[c]   = int'(o_CLK[c]);
      pc[c]   = int'(o_PCEN[c]);
      nc[c]   = int'(o_NCEN[c]);
    end
    if ((o_PCEN & o_NCEN) != 0) both = 1'b1;
    for (int i = 1; i <= nsamp; i++) begin
      @(negedge clk);
      if (i == hlen) hold = '0;
      if (sync_at >= 0 && i == sync_at) sync_n = 1'b0;
      if (sync_at >= 0 && i == sync_at + 1) sync_n = 1'b1;
      if (toggle) ncen = (i % 2 == 1);
      #1;
      cur = o_CLK;
      if ((o_PCEN & o_NCEN) != 0) both = 1'b1;
      if (!ncen && ((o_PCEN | o_NCEN) != 0)) gated = 1'b1;
      for (int c = 0; c < 3; c++) begin
        if (cur[c] && !prev[c]) begin
          if (last[c] >= 0) begin
            have = 1'b0;
            if (c == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            else if (c == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            else if (c == 2 && q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            if (have) begin
              checks++;
              if ((i - last[c]) != e.per || hi[c] != e.hi || pc[c] != 1 || nc[c] != 1) begin
                failures++;
                $display("FAIL %s ch%0d period/high/pcen/ncen got %0d/%0d/%0d/%0d expected %0d/%0d/1/1",
                         tag, c, i - last[c], hi[c], pc[c], nc[c], e.per, e.hi);
              end
            end
          end
          last[c] = i;
          hi[c]   = 0;
          pc[c]   = 0;
          nc[c]   = 0;
        end
        hi[c] += int'(cur[c]);
        pc[c] += int'(o_PCEN[c]);
        nc[c] += int'(o_NCEN[c]);
      end
      prev = cur;
    end
    checks++;
    if (both) begin
      failures++;
      $display("FAIL %s pcen_ncen_overlap got 1 expected 0", tag);
    end
    if (toggle) begin
      checks++;
      if (gated) begin
        failures++;
        $display("FAIL %s strobe_while_ncen_low got 1 expected 0", tag);
      end
    end
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      failures++;
      $display("FAIL %s missing_periods got %0d unmatched expected 0", tag,
               q0.size() + q1.size() + q2.size());
    end
    q0.delete();
    q1.delete();
    q2.delete();
    hold   = '0;
    sync_n = 1'b1;
    ncen   = 1'b1;
  endtask

  task automatic test_startup(input string tag);
    int rise;
    bit bad;
    rise  = -1;
    bad   = 1'b0;
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk); #1;
      if (o_READY) begin
        rise = k;
        break;
      end
      if (o_CLK != '0 || o_PCEN != '0 || o_NCEN != '0) bad = 1'b1;
    end
    checks++;
    if (rise != RST_DLY) begin
      failures++;
      $display("FAIL %s ready_delay got %0d expected %0d", tag, rise, RST_DLY);
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL %s activity_before_ready got 1 expected 0", tag);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    ncen   = 1'b1;
    div    = {4'd5, 4'd3, 4'd1};
    hold   = '0;
    sync_n = 1'b1;
    mask   = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (o_CLK !== 3'b000) begin
      failures++;
      $display("FAIL reset_clk got %b expected 000", o_CLK);
    end
    checks++;
    if (o_READY !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got %b expected 0", o_READY);
    end
    checks++;
    if ((o_PCEN | o_NCEN) !== 3'b000) begin
      failures++;
      $display("FAIL reset_strobes got %b/%b expected 000/000", o_PCEN, o_NCEN);
    end
  endtask

  task automatic test_free_run();
    push_exp(0, 2, 1, 15);
    push_exp(1, 4, 2, 8);
    push_exp(2, 6, 3, 5);
    measure("free_run", 40, 3'b000, 3'b000, 0, -1, 1'b0);
  endtask

  task automatic test_div_change();
    wait_rise(1, "div_change");
    div[7:4] = 4'd2;
    push_exp(1, 4, 2, 1);
    push_exp(1, 3, 2, 3);
    measure("div_change", 16, 3'b010, 3'b000, 0, -1, 1'b0);
  endtask

  task automatic test_hold();
    wait_rise(2, "hold");
    push_exp(2, 11, 8, 1);
    push_exp(2, 6, 3, 2);
    measure("hold", 30, 3'b100, 3'b100, 5, -1, 1'b0);
  endtask

  task automatic test_sync();
    div[7:4] = 4'd3;
    mask     = 3'b010;
    wait_rise(1, "sync");
    wait_rise(1, "sync");
    push_exp(1, 3, 2, 1);
    push_exp(1, 4, 2, 3);
    push_exp(0, 2, 1, 8);
    push_exp(2, 6, 3, 3);
    measure("sync", 24, 3'b010, 3'b000, 0, 0, 1'b0);
    mask = '0;
  endtask

  task automatic test_div_max();
    div[7:4] = 4'hF;
    push_exp(1, 16, 8, 2);
    measure("div_max", 40, 3'b000, 3'b000, 0, -1, 1'b0);
    div[7:4] = 4'd3;
    wait_rise(1, "div_max");
  endtask

  task automatic test_ncen_toggle();
    push_exp(0, 4, 2, 6);
    push_exp(1, 8, 4, 4);
    push_exp(2, 12, 6, 3);
    measure("ncen_toggle", 60, 3'b000, 3'b000, 0, -1, 1'b1);
  endtask

  task automatic test_reset_mid();
    wait_rise(2, "reset_mid");
    repeat (4) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ((o_PCEN | o_NCEN) !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid_strobes_comb got %b/%b expected 000/000", o_PCEN, o_NCEN);
    end
    @(negedge clk); #1;
    checks++;
    if (o_CLK !== 3'b000 || o_READY !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_state got clk=%b ready=%b expected clk=000 ready=0", o_CLK, o_READY);
    end
    checks++;
    if ((o_PCEN | o_NCEN) !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid_strobes got %b/%b expected 000/000", o_PCEN, o_NCEN);
    end
    div[3:0] = 4'd0;
    test_startup("reset_mid_startup");
    push_exp(0, 2, 1, 8);
    push_exp(2, 6, 3, 2);
    measure("div_zero", 24, 3'b000, 3'b000, 0, -1, 1'b0);
  endtask

`ifdef IKA9958_CENGEN_LOCKDET_EN
  task automatic sync_pulse(input bit aligned);
    for (int k = 0; k < 4 && (o_CLK[0] != !aligned); k++) begin
      @(negedge clk); #1;
    end
    sync_n = 1'b0;
    @(negedge clk); #1;
    sync_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
  endtask

  task automatic test_lockdet();
    mask = '0;
    sync_pulse(1'b1);
    sync_pulse(1'b1);
    checks++;
    if (o_LOCKED !== 1'b0) begin
      failures++;
      $display("FAIL lock_after_two got %b expected 0", o_LOCKED);
    end
    sync_pulse(1'b1);
    checks++;
    if (o_LOCKED !== 1'b1) begin
      failures++;
      $display("FAIL lock_after_three got %b expected 1", o_LOCKED);
    end
    sync_pulse(1'b0);
    checks++;
    if (o_LOCKED !== 1'b0) begin
      failures++;
      $display("FAIL lock_misaligned got %b expected 0", o_LOCKED);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_startup("startup");
    test_free_run();
    test_div_change();
    test_hold();
    test_sync();
    test_div_max();
    test_ncen_toggle();
    test_reset_mid();
`ifdef IKA9958_CENGEN_LOCKDET_EN
    test_lockdet();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
